// File: rtl/cg_bound_counter.sv
// cg_bound_counter
//   Synchronous up/down counter with programmable step, programmable
//   [min,max] bounds, wrap or saturate behaviour at the bounds, parallel
//   load, pause, and bound-event reporting (one-cycle pulse plus sticky flag).
//
// Ports
//   i_clk         clock, all state updates on the rising edge
//   i_rstn        synchronous active-low reset
//   i_load        load o_count with i_load_value (beats i_en)
//   i_load_value  parallel load value, not clamped to the bounds
//   i_en          count enable, 0 = hold
//   i_dir         0 = count up, 1 = count down
//   i_step        unsigned step magnitude
//   i_min, i_max  unsigned bounds, caller keeps i_min <= i_max
//   i_sat         1 = saturate at the bound, 0 = wrap to the opposite bound
//   i_clr_flag    clear o_evt_sticky (a simultaneous new event wins)
//   o_count       registered count
//   o_evt         registered pulse: the previous update hit a bound
//   o_evt_sticky  sticky bound-event flag
module cg_bound_counter #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_value,
    input  logic                  i_en,
    input  logic                  i_dir,
    input  logic [DATA_WIDTH-1:0] i_step,
    input  logic [DATA_WIDTH-1:0] i_min,
    input  logic [DATA_WIDTH-1:0] i_max,
    input  logic                  i_sat,
    input  logic                  i_clr_flag,
    output logic [DATA_WIDTH-1:0] o_count,
    output logic                  o_evt,
    output logic                  o_evt_sticky
);

    // One extra bit keeps the carry of the add and the borrow of the subtract.
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic                  up_evt;
    logic                  dn_evt;
    logic [DATA_WIDTH-1:0] count_next;
    logic                  evt_next;

    assign sum    = {1'b0, o_count} + {1'b0, i_step};
    assign diff   = {1'b0, o_count} - {1'b0, i_step};
    assign up_evt = (sum > {1'b0, i_max});
    // A set top bit of diff means the subtract borrowed.
    assign dn_evt = diff[DATA_WIDTH] || (diff[DATA_WIDTH-1:0] < i_min);

    always_comb begin
        count_next = o_count;
        evt_next   = 1'b0;
        if (i_load) begin
            count_next = i_load_value;
        end else if (i_en) begin
            if (!i_dir) begin
                if (up_evt) begin
                    evt_next   = 1'b1;
                    count_next = i_sat ? i_max : i_min;
                end else begin
                    count_next = sum[DATA_WIDTH-1:0];
                end
            end else begin
                if (dn_evt) begin
                    evt_next   = 1'b1;
                    count_next = i_sat ? i_min : i_max;
                end else begin
                    count_next = diff[DATA_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_count      <= RESET_VALUE;
            o_evt        <= 1'b0;
            o_evt_sticky <= 1'b0;
        end else begin
            o_count      <= count_next;
            o_evt        <= evt_next;
            // A new event on the same edge as a clear leaves the flag set.
            o_evt_sticky <= evt_next | (o_evt_sticky & ~i_clr_flag);
        end
    end

endmodule

// File: tb/tb_cg_bound_counter.sv
// tb_cg_bound_counter
//   Self-checking bench for cg_bound_counter at DATA_WIDTH=8. Directed
//   scenarios check literal expected sequences; a randomized phase checks
//   every cycle against an integer-arithmetic reference model.
module tb_cg_bound_counter;

    localparam int DW = 8;

    logic          clk;
    logic          rstn;
    logic          load;
    logic [DW-1:0] load_value;
    logic          en;
    logic          dir;
    logic [DW-1:0] step;
    logic [DW-1:0] min_b;
    logic [DW-1:0] max_b;
    logic          sat;
    logic          clr_flag;
    logic [DW-1:0] count;
    logic          evt;
    logic          evt_sticky;

    int total = 0;
    int bad   = 0;

    // Reference model state, plain integers.
    int m_count  = 0;
    int m_evt    = 0;
    int m_sticky = 0;

    cg_bound_counter #(
        .DATA_WIDTH (DW),
        .RESET_VALUE(8'd0)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_load      (load),
        .i_load_value(load_value),
        .i_en        (en),
        .i_dir       (dir),
        .i_step      (step),
        .i_min       (min_b),
        .i_max       (max_b),
        .i_sat       (sat),
        .i_clr_flag  (clr_flag),
        .o_count     (count),
        .o_evt       (evt),
        .o_evt_sticky(evt_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: apply the counter rules with signed integer arithmetic,
    // so a "borrow" is simply a negative result and a carry is a value > 255.
    function automatic void model_update();
        int ev;
        ev = 0;
        if (!rstn) begin
            m_count  = 0;
            m_evt    = 0;
            m_sticky = 0;
            return;
        end
        if (load) begin
            m_count = int'(load_value);
        end else if (en) begin
            if (!dir) begin
                if (m_count + int'(step) > int'(max_b)) begin
                    ev = 1;
                    m_count = sat ? int'(max_b) : int'(min_b);
                end else begin
                    m_count = m_count + int'(step);
                end
            end else begin
                if (m_count - int'(step) < int'(min_b)) begin
                    ev = 1;
                    m_count = sat ? int'(min_b) : int'(max_b);
                end else begin
                    m_count = m_count - int'(step);
                end
            end
        end
        m_evt    = ev;
        m_sticky = (ev != 0 || (m_sticky != 0 && !clr_flag)) ? 1 : 0;
    endfunction

    // Advance one clock with the currently driven inputs; sample 1 ns later.
    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load = 0; load_value = 0; en = 0; dir = 0; step = 0;
        min_b = 0; max_b = 8'd255; sat = 0; clr_flag = 0;
    endtask

    task automatic test_reset();
        rstn = 0; idle_inputs();
        load = 1; load_value = 8'd55; en = 1; step = 8'd3;
        tick();
        total++;
        if (count !== 8'd0 || evt !== 1'b0 || evt_sticky !== 1'b0) begin
            bad++;
            $display("FAIL reset_state count=%0d evt=%0b sticky=%0b need 0/0/0", count, evt, evt_sticky);
        end
        tick();
        total++;
        if (count !== 8'd0) begin
            bad++;
            $display("FAIL reset_overrides_load count=%0d need 0", count);
        end
        rstn = 1; load = 0; en = 0;
        tick();
        total++;
        if (count !== 8'd0 || evt !== 1'b0) begin
            bad++;
            $display("FAIL reset_release count=%0d evt=%0b need 0/0", count, evt);
        end
    endtask

    task automatic test_wrap_up();
        int exp_c [4] = '{5, 8, 2, 5};
        int exp_e [4] = '{0, 0, 1, 0};
        int exp_s [4] = '{0, 0, 1, 1};
        idle_inputs();
        min_b = 8'd2; max_b = 8'd10; step = 8'd3;
        load = 1; load_value = 8'd2; clr_flag = 1;
        tick();
        total++;
        if (count !== 8'd2 || evt !== 1'b0) begin
            bad++;
            $display("FAIL wrap_up_load count=%0d evt=%0b need 2/0", count, evt);
        end
        load = 0; clr_flag = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (count !== DW'(exp_c[i]) || evt !== exp_e[i][0] || evt_sticky !== exp_s[i][0]) begin
                bad++;
                $display("FAIL wrap_up_step%0d count=%0d evt=%0b sticky=%0b need %0d/%0d/%0d",
                         i, count, evt, evt_sticky, exp_c[i], exp_e[i], exp_s[i]);
            end
        end
        // Plain clear.
        en = 0; clr_flag = 1;
        tick();
        total++;
        if (evt_sticky !== 1'b0 || count !== 8'd5) begin
            bad++;
            $display("FAIL sticky_clear sticky=%0b count=%0d need 0/5", evt_sticky, count);
        end
        // 5 -> 8, then the wrap edge coincides with a clear: set wins.
        en = 1; clr_flag = 0;
        tick();
        clr_flag = 1;
        tick();
        total++;
        if (count !== 8'd2 || evt !== 1'b1 || evt_sticky !== 1'b1) begin
            bad++;
            $display("FAIL sticky_set_wins count=%0d evt=%0b sticky=%0b need 2/1/1", count, evt, evt_sticky);
        end
        clr_flag = 0; en = 0;
        tick();
    endtask

    task automatic test_sat_down();
        int exp_c [4] = '{5, 2, 2, 2};
        int exp_e [4] = '{0, 1, 1, 1};
        idle_inputs();
        min_b = 8'd2; max_b = 8'd10; step = 8'd4; sat = 1; dir = 1;
        load = 1; load_value = 8'd9;
        tick();
        load = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (count !== DW'(exp_c[i]) || evt !== exp_e[i][0]) begin
                bad++;
                $display("FAIL sat_down_step%0d count=%0d evt=%0b need %0d/%0d",
                         i, count, evt, exp_c[i], exp_e[i]);
            end
        end
    endtask

    task automatic test_borrow_carry();
        idle_inputs();
        min_b = 8'd0; max_b = 8'd255; step = 8'd1; dir = 1;
        load = 1; load_value = 8'd0;
        tick();
        load = 0; en = 1;
        tick();
        total++;
        if (count !== 8'd255 || evt !== 1'b1) begin
            bad++;
            $display("FAIL borrow_wrap count=%0d evt=%0b need 255/1", count, evt);
        end
        dir = 0;
        tick();
        total++;
        if (count !== 8'd0 || evt !== 1'b1) begin
            bad++;
            $display("FAIL carry_wrap count=%0d evt=%0b need 0/1", count, evt);
        end
    endtask

    task automatic test_load_priority();
        idle_inputs();
        min_b = 8'd7; max_b = 8'd100; step = 8'd5;
        load = 1; load_value = 8'd200; en = 1; dir = 0;
        tick();
        total++;
        if (count !== 8'd200 || evt !== 1'b0) begin
            bad++;
            $display("FAIL load_priority count=%0d evt=%0b need 200/0", count, evt);
        end
        load = 0; step = 8'd0; sat = 1;
        tick();
        total++;
        if (count !== 8'd100 || evt !== 1'b1) begin
            bad++;
            $display("FAIL out_of_range_sat count=%0d evt=%0b need 100/1", count, evt);
        end
        load = 1; load_value = 8'd200; sat = 0;
        tick();
        load = 0;
        tick();
        total++;
        if (count !== 8'd7 || evt !== 1'b1) begin
            bad++;
            $display("FAIL out_of_range_wrap count=%0d evt=%0b need 7/1", count, evt);
        end
        // Below min while counting up is an ordinary add.
        load = 1; load_value = 8'd1; step = 8'd2;
        tick();
        load = 0;
        tick();
        total++;
        if (count !== 8'd3 || evt !== 1'b0) begin
            bad++;
            $display("FAIL below_min_up count=%0d evt=%0b need 3/0", count, evt);
        end
    endtask

    task automatic test_pause();
        logic en_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int   exp_c  [4] = '{1, 1, 2, 2};
        idle_inputs();
        step = 8'd1; max_b = 8'd255;
        load = 1; load_value = 8'd0;
        tick();
        load = 0;
        for (int i = 0; i < 4; i++) begin
            en = en_seq[i];
            tick();
            total++;
            if (count !== DW'(exp_c[i]) || evt !== 1'b0) begin
                bad++;
                $display("FAIL pause_step%0d count=%0d evt=%0b need %0d/0", i, count, evt, exp_c[i]);
            end
        end
    endtask

    task automatic test_random();
        int a, b;
        for (int i = 0; i < 600; i++) begin
            rstn       = ($urandom_range(0, 99) != 0);
            load       = ($urandom_range(0, 9) == 0);
            load_value = DW'($urandom);
            en         = ($urandom_range(0, 3) != 0);
            dir        = $urandom_range(0, 1);
            sat        = $urandom_range(0, 1);
            clr_flag   = ($urandom_range(0, 5) == 0);
            step       = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 6));
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) begin
                min_b = 8'd0; max_b = 8'd255;
            end else begin
                min_b = DW'((a < b) ? a : b);
                max_b = DW'((a < b) ? b : a);
            end
            tick();
            total++;
            if (count !== DW'(m_count) || evt !== m_evt[0] || evt_sticky !== m_sticky[0]) begin
                bad++;
                $display("FAIL random_%0d count=%0d evt=%0b sticky=%0b need %0d/%0d/%0d",
                         i, count, evt, evt_sticky, m_count, m_evt, m_sticky);
            end
        end
        rstn = 1;
    endtask

    initial begin
        rstn = 0;
        idle_inputs();
        #2;
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_borrow_carry();
        test_load_priority();
        test_pause();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
